usb_slave_fifo_controller: RTL and testbench

USB_SLAVE_FIFO_CONTROLLER -- requirements
Module: usb_slave_fifo_controller

---
 rtl/usb_slave_fifo_controller.sv | 207 ++++++++++++++++++++
 tb/tb_usb_slave_fifo_controller.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_slave_fifo_controller.sv
// FX2 slave-FIFO master: drains EP2 (OUT) into the rx stream and fills EP6 (IN) from the tx stream.
// Define USB_PKTEND_EN to commit partial IN packets on tx_flush or after FLUSH_IDLE idle cycles.
module usb_slave_fifo_controller #(
  parameter int RD_BURST_MAX = 256,
  parameter int WR_PKT_WORDS = 256,
  parameter int FLUSH_IDLE   = 1024
) (
  input  logic        IFCLK,
  input  logic        rst,
  input  logic        usb_flagB_in,
  input  logic        usb_flagC_in,
  input  logic [15:0] usb_fd_in,
  output logic [15:0] usb_fd_out,
  output logic        usb_sloe,
  output logic        usb_slrd,
  output logic        usb_slwr,
  output logic        usb_pktend,
  output logic [1:0]  usb_fifo_adr,
  output logic [15:0] rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  input  logic [15:0] tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  input  logic        tx_flush
);

  localparam int RW = $clog2(RD_BURST_MAX) + 1;
  localparam int PW = $clog2(WR_PKT_WORDS) + 1;
  localparam logic [1:0]    ADR_EP2  = 2'b00;
  localparam logic [1:0]    ADR_EP6  = 2'b10;
  localparam logic [RW-1:0] RD_MAX   = RW'(RD_BURST_MAX);
  localparam logic [PW-1:0] PKT_LAST = PW'(WR_PKT_WORDS - 1);

`ifdef USB_PKTEND_EN
  localparam int IW = $clog2(FLUSH_IDLE) + 1;
  localparam logic [IW-1:0] IDLE_MAX = IW'(FLUSH_IDLE);

  typedef enum logic [2:0] {
    IDLE, RD_SETUP, RD_DATA, TURN, WR_SETUP, WR_DATA, PKTEND
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, RD_SETUP, RD_DATA, TURN, WR_SETUP, WR_DATA
  } state_t;
`endif

  state_t          state_q, state_d;
  logic            sloe_q, sloe_d;
  logic [1:0]      adr_q, adr_d;
  logic [15:0]     rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic [RW-1:0]   rd_cnt_q, rd_cnt_d;
  logic [PW-1:0]   pkt_cnt_q, pkt_cnt_d;
  logic            last_rd_q, last_rd_d;
  logic            rd_req, wr_req, rd_beat, wr_beat, go_flush;

`ifdef USB_PKTEND_EN
  logic            pktend_q, pktend_d;
  logic            pk_phase_q, pk_phase_d;
  logic            flush_pend_q, flush_pend_d;
  logic [IW-1:0]   idle_cnt_q, idle_cnt_d;

  assign go_flush   = (pkt_cnt_q != '0) && (flush_pend_q || idle_cnt_q == IDLE_MAX);
  assign usb_pktend = pktend_q;
`else
  logic                      unused_flush;
  logic [$clog2(FLUSH_IDLE):0] unused_idle;

  assign unused_flush = tx_flush;
  assign unused_idle  = '0;
  assign go_flush     = 1'b0;
  assign usb_pktend   = 1'b1;
`endif

  assign rd_req = usb_flagB_in & rx_ready;
  assign wr_req = usb_flagC_in & tx_valid;

  // Strobes decode straight from registered state so the FIFO sees them in the cycle its flags allow it.
  assign rd_beat = (state_q == RD_DATA) && usb_flagB_in && rx_ready && (rd_cnt_q != RD_MAX);
  assign wr_beat = (state_q == WR_DATA) && tx_valid && usb_flagC_in;

  assign usb_slrd     = ~rd_beat;
  assign usb_slwr     = ~wr_beat;
  assign tx_ready     = wr_beat;
  assign usb_fd_out   = (state_q == WR_DATA) ? tx_data : 16'h0000;
  assign usb_sloe     = sloe_q;
  assign usb_fifo_adr = adr_q;
  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;

  always_comb begin
    state_d    = state_q;
    adr_d      = adr_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rd_cnt_d   = rd_cnt_q;
    pkt_cnt_d  = pkt_cnt_q;
    last_rd_d  = last_rd_q;
`ifdef USB_PKTEND_EN
    pktend_d     = 1'b1;
    pk_phase_d   = 1'b0;
    flush_pend_d = flush_pend_q | tx_flush;
    if (tx_valid || pkt_cnt_q == '0)  idle_cnt_d = '0;
    else if (idle_cnt_q != IDLE_MAX)  idle_cnt_d = idle_cnt_q + IW'(1);
    else                              idle_cnt_d = idle_cnt_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef USB_PKTEND_EN
        // A flush with nothing buffered has nothing to commit.
        if (pkt_cnt_q == '0) flush_pend_d = 1'b0;
`endif
        if (go_flush) begin
`ifdef USB_PKTEND_EN
          state_d = PKTEND;
          adr_d   = ADR_EP6;
`endif
        end else if (rd_req && (!wr_req || !last_rd_q)) begin
          state_d   = RD_SETUP;
          adr_d     = ADR_EP2;
          rd_cnt_d  = '0;
          last_rd_d = 1'b1;
        end else if (wr_req) begin
          state_d   = WR_SETUP;
          adr_d     = ADR_EP6;
          last_rd_d = 1'b0;
        end
      end
      RD_SETUP: state_d = RD_DATA;
      RD_DATA: begin
        if (rd_beat) begin
          rx_data_d  = usb_fd_in;
          rx_valid_d = 1'b1;
          rd_cnt_d   = rd_cnt_q + RW'(1);
        end else begin
          state_d = TURN;
        end
      end
      TURN:     state_d = IDLE;
      WR_SETUP: state_d = WR_DATA;
      WR_DATA: begin
        if (wr_beat) begin
          // The FX2 commits a full packet on its own, so wrap and re-arbitrate.
          if (pkt_cnt_q == PKT_LAST) begin
            pkt_cnt_d = '0;
            state_d   = IDLE;
          end else begin
            pkt_cnt_d = pkt_cnt_q + PW'(1);
          end
        end else begin
          state_d = IDLE;
        end
      end
`ifdef USB_PKTEND_EN
      PKTEND: begin
        // First cycle holds the address steady, second carries the pktend pulse.
        if (!pk_phase_q) begin
          pk_phase_d = 1'b1;
          pktend_d   = 1'b0;
        end else begin
          pkt_cnt_d    = '0;
          flush_pend_d = 1'b0;
          state_d      = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    sloe_d = !(state_d == RD_SETUP || state_d == RD_DATA);
  end

  always_ff @(posedge IFCLK) begin
    if (rst) begin
      state_q    <= IDLE;
      sloe_q     <= 1'b1;
      adr_q      <= ADR_EP2;
      rx_data_q  <= 16'h0000;
      rx_valid_q <= 1'b0;
      rd_cnt_q   <= '0;
      pkt_cnt_q  <= '0;
      last_rd_q  <= 1'b0;
`ifdef USB_PKTEND_EN
      pktend_q     <= 1'b1;
      pk_phase_q   <= 1'b0;
      flush_pend_q <= 1'b0;
      idle_cnt_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      sloe_q     <= sloe_d;
      adr_q      <= adr_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rd_cnt_q   <= rd_cnt_d;
      pkt_cnt_q  <= pkt_cnt_d;
      last_rd_q  <= last_rd_d;
`ifdef USB_PKTEND_EN
      pktend_q     <= pktend_d;
      pk_phase_q   <= pk_phase_d;
      flush_pend_q <= flush_pend_d;
      idle_cnt_q   <= idle_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_usb_slave_fifo_controller.sv
// Directed bench for usb_slave_fifo_controller: per-cycle vector table plus burst, wrap, stall and flush sequences.
module tb_usb_slave_fifo_controller;

  logic        IFCLK;
  logic        rst;
  logic        usb_flagB_in, usb_flagC_in;
  logic [15:0] usb_fd_in, usb_fd_out;
  logic        usb_sloe, usb_slrd, usb_slwr, usb_pktend;
  logic [1:0]  usb_fifo_adr;
  logic [15:0] rx_data;
  logic        rx_valid, rx_ready;
  logic [15:0] tx_data;
  logic        tx_valid, tx_ready, tx_flush;

  usb_slave_fifo_controller dut (
    .IFCLK(IFCLK), .rst(rst),
    .usb_flagB_in(usb_flagB_in), .usb_flagC_in(usb_flagC_in),
    .usb_fd_in(usb_fd_in), .usb_fd_out(usb_fd_out),
    .usb_sloe(usb_sloe), .usb_slrd(usb_slrd), .usb_slwr(usb_slwr),
    .usb_pktend(usb_pktend), .usb_fifo_adr(usb_fifo_adr),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_flush(tx_flush)
  );

  initial IFCLK = 1'b0;
  always #5 IFCLK = ~IFCLK;

`ifdef USB_PKTEND_EN
  localparam int EXP_PK = 1;
`else
  localparam int EXP_PK = 0;
`endif

  typedef struct {
    logic        r, fb, fc, rdy, txv;
    logic [15:0] fd, txd;
    logic [39:0] exp;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int inv_bad = 0;
  int pk_low  = 0;
  logic [1:0] prev_adr = 2'b00;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Per-cycle protocol rules observed on every sampled cycle.
  task automatic watch();
    cyc++;
    if (!usb_slrd && !usb_slwr) inv_bad++;
    if (!usb_slwr && !usb_sloe) inv_bad++;
    if (!usb_slrd && usb_sloe) inv_bad++;
    if (!usb_slrd && (usb_fifo_adr != 2'b00 || prev_adr != 2'b00)) inv_bad++;
    if (!usb_slwr && (usb_fifo_adr != 2'b10 || prev_adr != 2'b10)) inv_bad++;
    if (!usb_pktend) begin
      pk_low++;
      if (usb_fifo_adr != 2'b10 || prev_adr != 2'b10) inv_bad++;
    end
    prev_adr = usb_fifo_adr;
  endtask

  task automatic idle_inputs();
    usb_flagB_in = 1'b0; usb_flagC_in = 1'b0; usb_fd_in = 16'h0000;
    rx_ready = 1'b0; tx_data = 16'h0000; tx_valid = 1'b0; tx_flush = 1'b0;
  endtask

  task automatic do_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge IFCLK);
      rst = 1'b1; idle_inputs();
      #2 watch();
    end
    @(negedge IFCLK);
    rst = 1'b0;
    #2 watch();
  endtask

  function automatic logic [39:0] ex(input logic sloe, slrd, slwr, pk, input logic [1:0] adr,
                                     input logic rxv, input logic [15:0] rxd, input logic txr,
                                     input logic [15:0] fdo);
    return {sloe, slrd, slwr, pk, adr, rxv, rxd, txr, fdo};
  endfunction

  function automatic vec_t mk(input logic r, fb, fc, rdy, txv, input logic [15:0] fd, txd,
                              input logic [39:0] e);
    vec_t v;
    v.r = r; v.fb = fb; v.fc = fc; v.rdy = rdy; v.txv = txv; v.fd = fd; v.txd = txd; v.exp = e;
    return v;
  endfunction

  task automatic run_write(input int n, input int drop_at, input int drop_len, input logic [15:0] base,
                           output int nw, output int derr, output int viol, output int gap,
                           output int setup_ok);
    int idx, dropped, post, t255;
    logic [1:0] lp_adr;
    logic lp_slwr;
    idx = 0; dropped = 0; post = 0; t255 = 0;
    nw = 0; derr = 0; viol = 0; gap = -1; setup_ok = 0;
    lp_adr = usb_fifo_adr; lp_slwr = usb_slwr;
    for (int b = 0; b < 3000 && post < 3; b++) begin
      @(negedge IFCLK);
      idle_inputs();
      tx_valid = (idx < n);
      tx_data  = base + 16'(idx);
      usb_flagC_in = !(idx == drop_at && dropped < drop_len);
      if (!usb_flagC_in) dropped++;
      #2 watch();
      if (!usb_flagC_in && (!usb_slwr || tx_ready)) viol++;
      if (!usb_slwr) begin
        if (idx == 0) setup_ok = (lp_adr == 2'b10 && lp_slwr) ? 1 : 0;
        if (usb_fd_out !== base + 16'(idx) || tx_ready !== 1'b1) derr++;
        if (idx == 255) t255 = cyc;
        if (idx == 256) gap = cyc - t255;
        idx++; nw++;
      end
      lp_adr = usb_fifo_adr; lp_slwr = usb_slwr;
      if (idx >= n) post++;
    end
  endtask

  vec_t tbl[21];

  initial begin
    int rd_idx, rx_cnt, rx_err, cur, done;
    int grants[$];
    logic [15:0] expq[$];
    logic prev_sloe, prev_slwr;
    logic [7:0] ev[$];
    int last_rd_cyc, turn_viol;
    int nw, derr, viol, gap, setup_ok, pk_before;
    logic [31:0] evw;

    rst = 1'b1;
    idle_inputs();

    //             r  fb fc rdy txv fd        txd        sloe slrd slwr pk adr    rxv rxd      txr fdo
    tbl[0]  = mk(1, 0, 0, 0, 0, 16'h0000, 16'h0000, ex(1, 1, 1, 1, 2'b00, 0, 16'h0000, 0, 16'h0000));
    tbl[1]  = mk(0, 1, 0, 1, 0, 16'hA001, 16'h0000, ex(1, 1, 1, 1, 2'b00, 0, 16'h0000, 0, 16'h0000));
    tbl[2]  = mk(0, 1, 0, 1, 0, 16'hA002, 16'h0000, ex(0, 1, 1, 1, 2'b00, 0, 16'h0000, 0, 16'h0000));
    tbl[3]  = mk(0, 1, 0, 1, 0, 16'hA003, 16'h0000, ex(0, 0, 1, 1, 2'b00, 0, 16'h0000, 0, 16'h0000));
    tbl[4]  = mk(0, 1, 0, 0, 0, 16'hA004, 16'h0000, ex(0, 1, 1, 1, 2'b00, 1, 16'hA003, 0, 16'h0000));
    tbl[5]  = mk(0, 1, 1, 1, 1, 16'hA004, 16'hB001, ex(1, 1, 1, 1, 2'b00, 0, 16'hA003, 0, 16'h0000));
    tbl[6]  = mk(0, 1, 1, 1, 1, 16'hA004, 16'hB001, ex(1, 1, 1, 1, 2'b00, 0, 16'hA003, 0, 16'h0000));
    tbl[7]  = mk(0, 1, 1, 1, 1, 16'hA004, 16'hB001, ex(1, 1, 1, 1, 2'b10, 0, 16'hA003, 0, 16'h0000));
    tbl[8]  = mk(0, 1, 1, 1, 1, 16'hA004, 16'hB001, ex(1, 1, 0, 1, 2'b10, 0, 16'hA003, 1, 16'hB001));
    tbl[9]  = mk(0, 1, 0, 1, 1, 16'hA004, 16'hB002, ex(1, 1, 1, 1, 2'b10, 0, 16'hA003, 0, 16'hB002));
    tbl[10] = mk(0, 1, 1, 1, 1, 16'hA004, 16'hB002, ex(1, 1, 1, 1, 2'b10, 0, 16'hA003, 0, 16'h0000));
    tbl[11] = mk(0, 1, 1, 1, 1, 16'hA005, 16'hB002, ex(0, 1, 1, 1, 2'b00, 0, 16'hA003, 0, 16'h0000));
    tbl[12] = mk(1, 1, 1, 1, 1, 16'hA005, 16'hB002, ex(0, 0, 1, 1, 2'b00, 0, 16'hA003, 0, 16'h0000));
    tbl[13] = mk(0, 1, 1, 1, 1, 16'hA006, 16'hB002, ex(1, 1, 1, 1, 2'b00, 0, 16'h0000, 0, 16'h0000));
    tbl[14] = mk(0, 0, 1, 1, 1, 16'hA006, 16'hB002, ex(0, 1, 1, 1, 2'b00, 0, 16'h0000, 0, 16'h0000));
    tbl[15] = mk(0, 0, 1, 1, 1, 16'hA006, 16'hB002, ex(0, 1, 1, 1, 2'b00, 0, 16'h0000, 0, 16'h0000));
    tbl[16] = mk(0, 0, 1, 1, 1, 16'hA006, 16'hC0DE, ex(1, 1, 1, 1, 2'b00, 0, 16'h0000, 0, 16'h0000));
    tbl[17] = mk(0, 0, 1, 1, 1, 16'hA006, 16'hC0DE, ex(1, 1, 1, 1, 2'b00, 0, 16'h0000, 0, 16'h0000));
    tbl[18] = mk(0, 0, 1, 1, 0, 16'hA006, 16'hC0DE, ex(1, 1, 1, 1, 2'b10, 0, 16'h0000, 0, 16'h0000));
    tbl[19] = mk(0, 0, 1, 1, 0, 16'hA006, 16'hC0DE, ex(1, 1, 1, 1, 2'b10, 0, 16'h0000, 0, 16'hC0DE));
    tbl[20] = mk(0, 0, 0, 0, 0, 16'h0000, 16'h0000, ex(1, 1, 1, 1, 2'b10, 0, 16'h0000, 0, 16'h0000));

    do_reset();
    for (int i = 0; i < 21; i++) begin
      @(negedge IFCLK);
      idle_inputs();
      rst = tbl[i].r; usb_flagB_in = tbl[i].fb; usb_flagC_in = tbl[i].fc; rx_ready = tbl[i].rdy;
      tx_valid = tbl[i].txv; usb_fd_in = tbl[i].fd; tx_data = tbl[i].txd;
      #2 watch();
      check($sformatf("vec%0d", i),
            64'({usb_sloe, usb_slrd, usb_slwr, usb_pktend, usb_fifo_adr, rx_valid, rx_data,
                 tx_ready, usb_fd_out}), 64'(tbl[i].exp));
    end

    // 300 queued OUT words: a full burst, re-arbitration, then the remainder.
    do_reset();
    rd_idx = 0; rx_cnt = 0; rx_err = 0; cur = 0; done = 0; prev_sloe = 1'b1;
    for (int b = 0; b < 1000 && done == 0; b++) begin
      @(negedge IFCLK);
      idle_inputs();
      rx_ready = 1'b1;
      usb_flagB_in = (rd_idx < 300);
      usb_fd_in = 16'h5000 + 16'(rd_idx);
      #2 watch();
      if (rx_valid) begin
        rx_cnt++;
        if (expq.size() == 0 || rx_data !== expq[0]) rx_err++;
        if (expq.size() != 0) void'(expq.pop_front());
      end
      if (!usb_slrd) begin
        expq.push_back(usb_fd_in);
        rd_idx++; cur++;
      end
      if (usb_sloe && !prev_sloe) begin
        grants.push_back(cur);
        cur = 0;
      end
      prev_sloe = usb_sloe;
      if (rd_idx == 300 && rx_cnt == 300 && grants.size() == 2) done = 1;
    end
    check("rd_done", 64'(done), 64'(1));
    check("rd_grants", 64'(grants.size()), 64'(2));
    check("rd_burst1", 64'(grants.size() > 0 ? grants[0] : -1), 64'(256));
    check("rd_burst2", 64'(grants.size() > 1 ? grants[1] : -1), 64'(44));
    check("rx_count", 64'(rx_cnt), 64'(300));
    check("rx_seq_err", 64'(rx_err), 64'(0));

    // Full packet plus two: wrap forces re-arbitration after word 256.
    do_reset();
    pk_before = pk_low;
    run_write(258, -1, 0, 16'hC000, nw, derr, viol, gap, setup_ok);
    check("wr_count", 64'(nw), 64'(258));
    check("wr_data_err", 64'(derr), 64'(0));
    check("wr_setup", 64'(setup_ok), 64'(1));
    check("wr_wrap_gap", 64'(gap), 64'(3));
    check("wr_no_pktend", 64'(pk_low - pk_before), 64'(0));

    // EP6 full after word 100: strobe drops at once and word 101 resumes later.
    do_reset();
    run_write(120, 100, 4, 16'hD000, nw, derr, viol, gap, setup_ok);
    check("stall_count", 64'(nw), 64'(120));
    check("stall_data_err", 64'(derr), 64'(0));
    check("stall_strobe", 64'(viol), 64'(0));

    // Both sides requesting continuously: grants alternate starting with read.
    do_reset();
    prev_sloe = 1'b1; prev_slwr = 1'b1; last_rd_cyc = -100; turn_viol = 0;
    for (int b = 0; b < 1200; b++) begin
      @(negedge IFCLK);
      idle_inputs();
      usb_flagB_in = 1'b1; rx_ready = 1'b1; usb_flagC_in = 1'b1; tx_valid = 1'b1;
      usb_fd_in = 16'(b); tx_data = 16'(b);
      #2 watch();
      if (!usb_sloe && prev_sloe) ev.push_back("R");
      if (!usb_slwr && prev_slwr) begin
        ev.push_back("W");
        if (cyc - last_rd_cyc < 5) turn_viol++;
      end
      if (!usb_slrd) last_rd_cyc = cyc;
      prev_sloe = usb_sloe; prev_slwr = usb_slwr;
    end
    evw = 32'h0;
    for (int k = 0; k < 4 && k < ev.size(); k++) evw = {evw[23:0], ev[k]};
    check("arb_events", 64'(ev.size() >= 4), 64'(1));
    check("arb_order", 64'(evw), 64'("RWRW"));
    check("arb_turn", 64'(turn_viol), 64'(0));

    // Ten words then a flush pulse; the pulse only exists with the commit feature built in.
    do_reset();
    run_write(10, -1, 0, 16'hE000, nw, derr, viol, gap, setup_ok);
    check("flush_words", 64'(nw), 64'(10));
    pk_before = pk_low;
    @(negedge IFCLK);
    idle_inputs();
    tx_flush = 1'b1;
    #2 watch();
    for (int b = 0; b < 1200; b++) begin
      @(negedge IFCLK);
      idle_inputs();
      #2 watch();
    end
    check("flush_pulses", 64'(pk_low - pk_before), 64'(EXP_PK));

    check("invariants", 64'(inv_bad), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
